// File: rtl/noc_local_inject_arbiter.sv
// Wormhole packet-level round-robin arbiter sharing one NoC local ingress channel among
// NUM_REQ requesters, with a single registered output stage toward the router.
module noc_local_inject_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MAX_PKT_LEN = 16,
  localparam int unsigned IdW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int unsigned CntW       = $clog2(MAX_PKT_LEN + 1)
) (
  input  logic                          noc_clk,
  input  logic                          noc_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_flit,
  input  logic [NUM_REQ-1:0]            req_is_header,
  input  logic [NUM_REQ-1:0]            req_is_tail,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_flit,
  input  logic                          out_vc_ready,
  output logic                          out_is_header,
  output logic                          out_is_tail,
  output logic [IdW-1:0]                grant_id,
  output logic                          busy,
  output logic                          proto_err
);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e                state_q;
  logic [IdW-1:0]        rr_ptr_q;
  logic [IdW-1:0]        lock_id_q;
  logic [CntW-1:0]       flit_cnt_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_flit_q;
  logic                  out_is_header_q;
  logic                  out_is_tail_q;
  logic [IdW-1:0]        grant_id_q;
  logic                  proto_err_q;

  logic                  slot_free;
  logic [NUM_REQ-1:0]    cand;
  logic                  win_found;
  logic [IdW-1:0]        win_id;
  logic [NUM_REQ-1:0]    ready;
  logic [IdW-1:0]        sel_id;
  logic                  accept;
  logic [DATA_WIDTH-1:0] sel_flit;
  logic                  sel_hdr;
  logic                  sel_tail;
  logic [IdW-1:0]        rr_next;

  assign slot_free = !out_valid_q || out_ready;
  assign cand      = req_valid & req_is_header;

  // First header candidate at or after rr_ptr, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      int unsigned idx;
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && cand[idx]) begin
        win_found = 1'b1;
        win_id    = IdW'(idx);
      end
    end
  end

  always_comb begin
    ready  = '0;
    sel_id = lock_id_q;
    if (state_q == StIdle) begin
      sel_id = win_id;
      if (slot_free && out_vc_ready && win_found) ready[win_id] = 1'b1;
    end else begin
      ready[lock_id_q] = slot_free;
    end
    // Nothing may be accepted while reset is held.
    req_ready = noc_rst_n ? ready : '0;
  end

  assign accept   = |(req_valid & req_ready);
  assign sel_flit = req_flit[int'(sel_id)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_hdr  = req_is_header[sel_id];
  assign sel_tail = req_is_tail[sel_id];
  assign rr_next  = (int'(win_id) == NUM_REQ - 1) ? '0 : win_id + IdW'(1);

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_q         <= StIdle;
      rr_ptr_q        <= '0;
      lock_id_q       <= '0;
      flit_cnt_q      <= '0;
      out_valid_q     <= 1'b0;
      out_flit_q      <= '0;
      out_is_header_q <= 1'b0;
      out_is_tail_q   <= 1'b0;
      grant_id_q      <= '0;
      proto_err_q     <= 1'b0;
    end else begin
      if (accept) begin
        out_valid_q     <= 1'b1;
        out_flit_q      <= sel_flit;
        out_is_header_q <= sel_hdr;
        out_is_tail_q   <= sel_tail;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (accept && state_q == StIdle) begin
        grant_id_q <= win_id;
        rr_ptr_q   <= rr_next;
        flit_cnt_q <= CntW'(1);
        if (!sel_tail) begin
          state_q   <= StLocked;
          lock_id_q <= win_id;
        end
      end else if (accept && state_q == StLocked) begin
        if (flit_cnt_q != CntW'(MAX_PKT_LEN)) flit_cnt_q <= flit_cnt_q + CntW'(1);
        if (sel_hdr || (flit_cnt_q == CntW'(MAX_PKT_LEN) && !sel_tail)) proto_err_q <= 1'b1;
        if (sel_tail) state_q <= StIdle;
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign out_flit      = out_flit_q;
  assign out_is_header = out_is_header_q;
  assign out_is_tail   = out_is_tail_q;
  assign grant_id      = grant_id_q;
  assign busy          = (state_q == StLocked) || out_valid_q;
  assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_noc_local_inject_arbiter.sv
// Self-checking bench: per-requester flit queues drive the arbiter, and a packet-level
// round-robin model predicts the forwarded flit stream.
module tb_noc_local_inject_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 16;
  localparam int MPL = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          hdr;
    logic          tail;
  } flit_t;

  logic              noc_clk = 1'b0;
  logic              noc_rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  req_flit;
  logic [NR-1:0]     req_is_header;
  logic [NR-1:0]     req_is_tail;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_flit;
  logic              out_vc_ready;
  logic              out_is_header;
  logic              out_is_tail;
  logic [1:0]        grant_id;
  logic              busy;
  logic              proto_err;

  always #5 noc_clk = ~noc_clk;

  noc_local_inject_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_PKT_LEN(MPL)
  ) dut (
    .noc_clk      (noc_clk),
    .noc_rst_n    (noc_rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_flit     (req_flit),
    .req_is_header(req_is_header),
    .req_is_tail  (req_is_tail),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_flit     (out_flit),
    .out_vc_ready (out_vc_ready),
    .out_is_header(out_is_header),
    .out_is_tail  (out_is_tail),
    .grant_id     (grant_id),
    .busy         (busy),
    .proto_err    (proto_err)
  );

  flit_t     rq [NR][$];
  flit_t     exp_q[$];
  flit_t     got_q[$];
  int        mdl_rr;
  int        checks;
  int        errors;
  int        ready_mode;   // 0: always 1, 1: random, 2: always 0
  int        vc_mode;
  int        acc_cnt [NR];
  logic      prev_stall;
  flit_t     prev_out;
  logic      chk_ready_en;
  logic [NR-1:0] chk_ready_val;

  function automatic logic mode_val(int mode);
    if (mode == 0) return 1'b1;
    if (mode == 2) return 1'b0;
    return ($urandom_range(0, 3) != 0);
  endfunction

  function automatic logic any_pending();
    for (int i = 0; i < NR; i++) if (rq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic make_pkt(input int id, input int len);
    flit_t f;
    for (int k = 0; k < len; k++) begin
      f.data = {id[3:0], 12'($urandom)};
      f.hdr  = (k == 0);
      f.tail = (k == len - 1);
      rq[id].push_back(f);
    end
  endtask

  // Packet-level round robin: each winner forwards its whole packet, pointer moves past it.
  task automatic build_expected();
    flit_t mq [NR][$];
    flit_t f;
    int    g;
    int    j;
    for (int i = 0; i < NR; i++) mq[i] = rq[i];
    forever begin
      g = -1;
      for (int k = 0; k < NR; k++) begin
        j = (mdl_rr + k) % NR;
        if (g < 0 && mq[j].size() > 0) g = j;
      end
      if (g < 0) break;
      do begin
        f = mq[g].pop_front();
        exp_q.push_back(f);
      end while (!f.tail && mq[g].size() > 0);
      mdl_rr = (g + 1) % NR;
    end
  endtask

  task automatic drive();
    req_valid     = '0;
    req_is_header = '0;
    req_is_tail   = '0;
    req_flit      = '0;
    for (int i = 0; i < NR; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i]          = 1'b1;
        req_flit[i*DW +: DW]  = rq[i][0].data;
        req_is_header[i]      = rq[i][0].hdr;
        req_is_tail[i]        = rq[i][0].tail;
      end
    end
    out_ready    = mode_val(ready_mode);
    out_vc_ready = mode_val(vc_mode);
  endtask

  task automatic cycle();
    flit_t cur;
    drive();
    @(negedge noc_clk);
    cur = flit_t'({out_flit, out_is_header, out_is_tail});
    if (prev_stall) begin
      checks++;
      if (!out_valid || cur !== prev_out) begin
        errors++;
        $display("FAIL stall_hold: got v=%0b %h required v=1 %h", out_valid, cur, prev_out);
      end
    end
    checks++;
    if ($countones(req_ready) > 1) begin
      errors++;
      $display("FAIL ready_onehot: got %b required at most one bit", req_ready);
    end
    if (chk_ready_en) begin
      checks++;
      if (req_ready !== chk_ready_val) begin
        errors++;
        $display("FAIL req_ready: got %b required %b", req_ready, chk_ready_val);
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_out   = cur;
    if (out_valid && out_ready) got_q.push_back(cur);
    for (int i = 0; i < NR; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        void'(rq[i].pop_front());
        acc_cnt[i]++;
      end
    end
    @(posedge noc_clk);
    #1;
  endtask

  task automatic drain_and_compare(input string name);
    int n;
    n = 0;
    while ((any_pending() || got_q.size() < exp_q.size()) && n < 2000) begin
      cycle();
      n++;
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d flits required %0d", name, got_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL %s_flit%0d: got %h required %h", name, k, got_q[k], exp_q[k]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    noc_rst_n = 1'b0;
    for (int i = 0; i < NR; i++) begin
      rq[i].delete();
      acc_cnt[i] = 0;
    end
    got_q.delete();
    exp_q.delete();
    mdl_rr       = 0;
    prev_stall   = 1'b0;
    chk_ready_en = 1'b0;
    drive();
    @(negedge noc_clk);
    noc_rst_n = 1'b1;
    @(posedge noc_clk);
    #1;
  endtask

  task automatic test_reset();
    ready_mode = 0;
    vc_mode    = 0;
    make_pkt(2, 4);
    cycle();
    cycle();
    noc_rst_n = 1'b0;
    #2;
    checks++;
    if ({out_valid, out_is_header, out_is_tail, out_flit, grant_id, busy, proto_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b h=%0b t=%0b f=%h g=%0d b=%0b e=%0b required all 0",
               out_valid, out_is_header, out_is_tail, out_flit, grant_id, busy, proto_err);
    end
    checks++;
    if (req_ready !== '0) begin
      errors++;
      $display("FAIL reset_ready: got %b required 0 (req_valid=%b)", req_ready, req_valid);
    end
    @(negedge noc_clk);
    checks++;
    if (req_ready !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got ready=%b v=%0b required 0/0", req_ready, out_valid);
    end
    do_reset();
  endtask

  task automatic test_single_pkt();
    ready_mode = 0;
    vc_mode    = 0;
    make_pkt(1, 3);
    build_expected();
    cycle();
    checks++;
    if (!(out_valid && out_is_header && !out_is_tail && grant_id == 2'd1 && busy)) begin
      errors++;
      $display("FAIL single_latency: got v=%0b h=%0b t=%0b g=%0d b=%0b required 1/1/0/1/1",
               out_valid, out_is_header, out_is_tail, grant_id, busy);
    end
    drain_and_compare("single");
    checks++;
    if (busy !== 1'b0 || grant_id !== 2'd1) begin
      errors++;
      $display("FAIL single_idle: got busy=%0b g=%0d required 0/1", busy, grant_id);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    ready_mode = 0;
    vc_mode    = 0;
    for (int r = 0; r < 2; r++) for (int i = 0; i < NR; i++) make_pkt(i, 2);
    build_expected();
    drain_and_compare("rr");
  endtask

  task automatic test_stall();
    int n;
    ready_mode = 0;
    vc_mode    = 0;
    make_pkt(2, 5);
    build_expected();
    n = 0;
    while (!(out_valid && !out_is_header) && n < 20) begin
      cycle();
      n++;
    end
    checks++;
    if (!(out_valid && !out_is_header)) begin
      errors++;
      $display("FAIL stall_setup: got v=%0b h=%0b required body flit on output",
               out_valid, out_is_header);
    end
    ready_mode    = 2;
    chk_ready_en  = 1'b1;
    chk_ready_val = '0;
    repeat (5) cycle();
    chk_ready_en = 1'b0;
    ready_mode   = 0;
    drain_and_compare("stall");
  endtask

  task automatic test_vc_gate();
    ready_mode    = 0;
    vc_mode       = 2;
    make_pkt(3, 2);
    build_expected();
    chk_ready_en  = 1'b1;
    chk_ready_val = '0;
    repeat (3) cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL vc_no_grant: got out_valid=%0b required 0", out_valid);
    end
    vc_mode       = 0;
    chk_ready_val = 4'b1000;
    cycle();
    chk_ready_en = 1'b0;
    checks++;
    if (!(out_valid && out_is_header && grant_id == 2'd3)) begin
      errors++;
      $display("FAIL vc_grant: got v=%0b h=%0b g=%0d required 1/1/3",
               out_valid, out_is_header, grant_id);
    end
    drain_and_compare("vc");
  endtask

  task automatic test_overlong();
    int n;
    ready_mode = 0;
    vc_mode    = 0;
    acc_cnt[0] = 0;
    make_pkt(0, 18);
    build_expected();
    n = 0;
    while (acc_cnt[0] < 16 && n < 100) begin
      cycle();
      n++;
    end
    checks++;
    if (acc_cnt[0] != 16 || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL err_at16: got acc=%0d err=%0b required 16/0", acc_cnt[0], proto_err);
    end
    cycle();
    checks++;
    if (acc_cnt[0] != 17 || proto_err !== 1'b1) begin
      errors++;
      $display("FAIL err_at17: got acc=%0d err=%0b required 17/1", acc_cnt[0], proto_err);
    end
    drain_and_compare("overlong");
    checks++;
    if (proto_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %0b required 1", proto_err);
    end
  endtask

  task automatic test_random();
    do_reset();
    ready_mode = 1;
    vc_mode    = 1;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NR; i++) begin
        int np;
        np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) make_pkt(i, $urandom_range(1, 6));
      end
      build_expected();
      drain_and_compare("random");
    end
    checks++;
    if (proto_err !== 1'b0) begin
      errors++;
      $display("FAIL random_err: got %0b required 0", proto_err);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    ready_mode   = 0;
    vc_mode      = 0;
    noc_rst_n    = 1'b0;
    prev_stall   = 1'b0;
    chk_ready_en = 1'b0;
    chk_ready_val = '0;
    mdl_rr       = 0;
    for (int i = 0; i < NR; i++) acc_cnt[i] = 0;
    drive();
    repeat (2) @(posedge noc_clk);
    do_reset();
    test_reset();
    test_single_pkt();
    test_round_robin();
    test_stall();
    test_vc_gate();
    test_overlong();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
